// File: rtl/seq_pkg.sv
// Shared definitions for the instruction stage sequencer: state encodings,
// halt opcode and default memory timeout.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [10:0] HLT_OPCODE          = 11'h6A2;
  localparam int          MEM_TIMEOUT_DEFAULT = 15;

  // Width needed to hold values 0..limit.
  function automatic int count_bits(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// MEMORY-state wait counter. terminal flags the increment that makes the
// count reach LIMIT, so the caller can fault on that same cycle.
module wait_counter
  import seq_pkg::*;
#(
  parameter int LIMIT = MEM_TIMEOUT_DEFAULT,
  parameter int W     = count_bits(LIMIT)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [W-1:0] count_q;

  // Clear has priority over counting; hold when not enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count_q <= '0;
    else if (clear)  count_q <= '0;
    else if (enable) count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
  end

  // Terminal count: this increment brings the count to LIMIT.
  always_comb begin
    terminal = enable && (count_q == W'(LIMIT - 1));
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK with HALT, memory timeout fault and a retired-instruction count.
//
// state     | meaning
// FETCH     | request instruction, load IR on instrReady
// DECODE    | one cycle, detect halt opcode
// EXECUTE   | ALU strobe, branch on decoded flags
// MEMORY    | data access until dataReady or timeout
// WRITEBACK | register write plus PC update
// HALT      | sticky stop until reset
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   instrReady,
  input  logic [31:0]            instruction,
  input  logic                   memRead,
  input  logic                   memWrite,
  input  logic                   regWriteFlag,
  input  logic                   branch,
  input  logic                   unconditionalBranch,
  input  logic                   dataReady,
  input  logic                   stall,
  output logic                   fetchRequest,
  output logic                   irLoad,
  output logic                   aluEnable,
  output logic                   memEnable,
  output logic                   regWriteEnable,
  output logic                   pcWrite,
  output logic [2:0]             state,
  output logic                   halted,
  output logic                   memFault,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  state_t                 state_q;
  logic                   mem_fault_q;
  logic [COUNT_WIDTH-1:0] retired_q;
  logic                   timeout;
  logic                   wait_clear;
  logic                   wait_enable;

  // Branch kind does not change sequencing; low instruction bits belong to
  // the datapath.
  logic unused_inputs;
  assign unused_inputs = ^{instruction[20:0], branch, unconditionalBranch};

  // Counter runs only in non-stalled MEMORY cycles still waiting on data.
  always_comb begin
    wait_clear  = (state_q != ST_MEMORY);
    wait_enable = (state_q == ST_MEMORY) && !stall && !dataReady;
  end

  wait_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (wait_clear),
    .enable   (wait_enable),
    .terminal (timeout)
  );

  // Combinational strobes and levels; stall suppresses pulses only.
  always_comb begin
    fetchRequest   = 1'b0;
    irLoad         = 1'b0;
    aluEnable      = 1'b0;
    memEnable      = 1'b0;
    regWriteEnable = 1'b0;
    pcWrite        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        fetchRequest = 1'b1;
        irLoad       = instrReady && !stall;
      end
      ST_EXECUTE: begin
        aluEnable = !stall;
        pcWrite   = !stall && !(memRead || memWrite) && !regWriteFlag;
      end
      ST_MEMORY: begin
        memEnable = 1'b1;
        pcWrite   = !stall && dataReady && !memRead;
      end
      ST_WRITEBACK: begin
        regWriteEnable = !stall;
        pcWrite        = !stall;
      end
      default: ;
    endcase
  end

  // State register, sticky fault and retirement counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      mem_fault_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      if (pcWrite) retired_q <= retired_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      case (state_q)
        ST_FETCH:
          if (!stall && instrReady) state_q <= ST_DECODE;
        ST_DECODE:
          if (!stall) state_q <= (instruction[31:21] == HLT_OPCODE) ? ST_HALT : ST_EXECUTE;
        ST_EXECUTE:
          if (!stall) begin
            if (memRead || memWrite) state_q <= ST_MEMORY;
            else if (regWriteFlag)   state_q <= ST_WRITEBACK;
            else                     state_q <= ST_FETCH;
          end
        ST_MEMORY:
          if (!stall) begin
            if (dataReady) begin
              state_q <= memRead ? ST_WRITEBACK : ST_FETCH;
            end else if (timeout) begin
              mem_fault_q <= 1'b1;
              state_q     <= ST_HALT;
            end
          end
        ST_WRITEBACK:
          if (!stall) state_q <= ST_FETCH;
        ST_HALT:
          state_q <= ST_HALT;
        default:
          state_q <= ST_HALT;
      endcase
    end
  end

  assign state        = state_q;
  assign halted       = (state_q == ST_HALT);
  assign memFault     = mem_fault_q;
  assign retiredCount = retired_q;

endmodule
